interrupt_acknowledge_sequencer: RTL and testbench

//   CPU-side partner of the KF8259 controller. Watches the controller's INT output.

---
 rtl/interrupt_acknowledge_sequencer.sv | 115 +++++++++++
 tb/tb_interrupt_acknowledge_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_acknowledge_sequencer.sv
// rtl/interrupt_acknowledge_sequencer.sv - two-pulse INTA# sequencer that fetches the 8259 vector for the CPU
module interrupt_acknowledge_sequencer #(
   parameter int unsigned INTA_WIDTH = 2,
   parameter int unsigned INTA_GAP   = 2,
   parameter int unsigned HOLDOFF    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       interrupt,
   input  logic       interrupt_enable,
   input  logic       cpu_ready,
   input  logic [7:0] data_bus_in,
   input  logic       vector_taken,
   output logic       interrupt_acknowledge_n,
   output logic [7:0] vector,
   output logic       vector_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PULSE1  = 3'd1,
      GAP     = 3'd2,
      PULSE2  = 3'd3,
      DELIVER = 3'd4,
      COOL    = 3'd5
   } state_t;

   localparam logic [7:0] WIDTH_LOAD = 8'(INTA_WIDTH - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(INTA_GAP - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLDOFF - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] count;
   logic [7:0] count_next;
   logic       capture;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                   <= IDLE;
         count                   <= 8'd0;
         interrupt_acknowledge_n <= 1'b1;
         vector                  <= 8'h00;
         vector_valid            <= 1'b0;
         busy                    <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         // Outputs are registered from the next state so they line up with the state itself.
         interrupt_acknowledge_n <= !((state_next == PULSE1) || (state_next == PULSE2));
         vector_valid            <= (state_next == DELIVER);
         busy                    <= (state_next != IDLE);
         if (capture) begin
            vector <= data_bus_in;
         end
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (interrupt && interrupt_enable && cpu_ready) begin
               state_next = PULSE1;
               count_next = WIDTH_LOAD;
            end
         end
         PULSE1: begin
            if (count == 8'd0) begin
               state_next = GAP;
               count_next = GAP_LOAD;
            end else begin
               count_next = count - 8'd1;
            end
         end
         GAP: begin
            if (count == 8'd0) begin
               state_next = PULSE2;
               count_next = WIDTH_LOAD;
            end else begin
               count_next = count - 8'd1;
            end
         end
         PULSE2: begin
            if (count == 8'd0) begin
               state_next = DELIVER;
               capture    = 1'b1;
            end else begin
               count_next = count - 8'd1;
            end
         end
         DELIVER: begin
            if (vector_taken) begin
               state_next = COOL;
               count_next = HOLD_LOAD;
            end
         end
         COOL: begin
            // interrupt is deliberately not looked at until IDLE is reached again.
            if (count == 8'd0) begin
               state_next = IDLE;
            end else begin
               count_next = count - 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// tb/tb_interrupt_acknowledge_sequencer.sv - directed scoreboard bench for interrupt_acknowledge_sequencer
module tb_interrupt_acknowledge_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;

   logic       interrupt = 1'b0, interrupt_enable = 1'b0, cpu_ready = 1'b0, vector_taken = 1'b0;
   logic [7:0] data_bus_in = 8'h00;
   logic       interrupt_acknowledge_n, vector_valid, busy;
   logic [7:0] vector;

   logic       b_interrupt = 1'b0, b_interrupt_enable = 1'b0, b_cpu_ready = 1'b0, b_vector_taken = 1'b0;
   logic [7:0] b_data_bus_in = 8'h00;
   logic       b_interrupt_acknowledge_n, b_vector_valid, b_busy;
   logic [7:0] b_vector;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb_a[$];
   logic [7:0] sb_b[$];
   logic [7:0] last_a = 8'h00;

   always #5 clock = ~clock;

   interrupt_acknowledge_sequencer dut_a (
      .clock(clock), .reset(reset), .interrupt(interrupt), .interrupt_enable(interrupt_enable),
      .cpu_ready(cpu_ready), .data_bus_in(data_bus_in), .vector_taken(vector_taken),
      .interrupt_acknowledge_n(interrupt_acknowledge_n), .vector(vector),
      .vector_valid(vector_valid), .busy(busy)
   );

   interrupt_acknowledge_sequencer #(.INTA_WIDTH(1), .INTA_GAP(1), .HOLDOFF(1)) dut_b (
      .clock(clock), .reset(reset), .interrupt(b_interrupt), .interrupt_enable(b_interrupt_enable),
      .cpu_ready(b_cpu_ready), .data_bus_in(b_data_bus_in), .vector_taken(b_vector_taken),
      .interrupt_acknowledge_n(b_interrupt_acknowledge_n), .vector(b_vector),
      .vector_valid(b_vector_valid), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Request already asserted; the next edge is the accept edge (cycle 0).
   task automatic seq_a(input logic [7:0] vec, input int drop_at, input logic taken_noise);
      logic [7:0] exp_v;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         tick();
         if (cyc == drop_at) interrupt = 1'b0;
         if (taken_noise && cyc == 1) vector_taken = 1'b1;
         if (taken_noise && cyc == 6) vector_taken = 1'b0;
         chk($sformatf("a_inta_n_c%0d", cyc), {7'd0, interrupt_acknowledge_n},
             (cyc == 1 || cyc == 2 || cyc == 5 || cyc == 6) ? 8'd0 : 8'd1);
         chk($sformatf("a_busy_c%0d", cyc), {7'd0, busy}, 8'd1);
         chk($sformatf("a_valid_c%0d", cyc), {7'd0, vector_valid}, (cyc == 7) ? 8'd1 : 8'd0);
         if (cyc == 5) begin
            data_bus_in = vec;
            sb_a.push_back(vec);
         end
         if (cyc == 7) begin
            exp_v = sb_a.pop_front();
            last_a = exp_v;
            chk("a_vector", vector, exp_v);
            data_bus_in = ~vec;
         end
      end
   endtask

   task automatic take_a(input int hold);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("a_hold_valid", {7'd0, vector_valid}, 8'd1);
         chk("a_hold_vector", vector, last_a);
      end
      vector_taken = 1'b1;
      tick();
      vector_taken = 1'b0;
      chk("a_cool1_valid", {7'd0, vector_valid}, 8'd0);
      chk("a_cool1_busy", {7'd0, busy}, 8'd1);
      tick();
      chk("a_cool2_busy", {7'd0, busy}, 8'd1);
      tick();
      chk("a_idle_busy", {7'd0, busy}, 8'd0);
      chk("a_idle_inta_n", {7'd0, interrupt_acknowledge_n}, 8'd1);
      chk("a_kept_vector", vector, last_a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b_inta [1:13] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
      logic [7:0] b_valid[1:13] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
      logic [7:0] b_bsy  [1:13] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
      logic [7:0] exp_v;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_inta_n", {7'd0, interrupt_acknowledge_n}, 8'd1);
      chk("rst_vector", vector, 8'h00);
      chk("rst_valid", {7'd0, vector_valid}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("b_rst_inta_n", {7'd0, b_interrupt_acknowledge_n}, 8'd1);
      reset = 1'b0;
      tick();

      interrupt = 1'b1; interrupt_enable = 1'b1; cpu_ready = 1'b1;
      seq_a(8'h0B, 1, 1'b0);
      take_a(3);

      interrupt = 1'b1; interrupt_enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("gated_inta_n", {7'd0, interrupt_acknowledge_n}, 8'd1);
         chk("gated_busy", {7'd0, busy}, 8'd0);
      end
      interrupt_enable = 1'b1;
      seq_a(8'h7E, 1, 1'b1);
      take_a(10);

      interrupt = 1'b1;
      seq_a(8'h99, 3, 1'b0);
      take_a(0);

      interrupt = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      tick();
      chk("abort_pulse2_inta_n", {7'd0, interrupt_acknowledge_n}, 8'd0);
      data_bus_in = 8'h5A;
      #3 reset = 1'b1;
      #1;
      chk("async_inta_n", {7'd0, interrupt_acknowledge_n}, 8'd1);
      chk("async_busy", {7'd0, busy}, 8'd0);
      chk("async_valid", {7'd0, vector_valid}, 8'd0);
      chk("async_vector", vector, 8'h00);
      #2 reset = 1'b0;
      seq_a(8'hC3, 2, 1'b0);
      take_a(0);

      b_interrupt = 1'b1; b_interrupt_enable = 1'b1; b_cpu_ready = 1'b1;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         tick();
         b_vector_taken = 1'b0;
         if (cyc == 7) b_interrupt = 1'b0;
         chk($sformatf("b_inta_n_c%0d", cyc), {7'd0, b_interrupt_acknowledge_n}, b_inta[cyc]);
         chk($sformatf("b_valid_c%0d", cyc), {7'd0, b_vector_valid}, b_valid[cyc]);
         chk($sformatf("b_busy_c%0d", cyc), {7'd0, b_busy}, b_bsy[cyc]);
         if (cyc == 3 || cyc == 9) begin
            b_data_bus_in = 8'(8'h20 + cyc);
            sb_b.push_back(b_data_bus_in);
         end
         if (cyc == 4 || cyc == 10) begin
            exp_v = sb_b.pop_front();
            chk($sformatf("b_vector_c%0d", cyc), b_vector, exp_v);
            b_data_bus_in = 8'hFF;
            b_vector_taken = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
